// File: rtl/irrig_pkg.sv
// Shared types and helpers for the irrigation controller: FSM state encoding and probe-consistency rule.
package irrig_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIP  = 2'd1,
      SPRAY = 2'd2,
      FAULT = 2'd3
   } irrig_state_t;

   // A probe wetted above a dry probe means a stuck or broken sensor.
   function automatic logic probe_err(input logic l, input logic m, input logic h);
      return (m & ~l) | (h & ~m);
   endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser followed by a stability filter: the output follows the synchronised
// input only after it has disagreed with the output for DEB_CYCLES consecutive cycles.
module sensor_debounce
   import irrig_pkg::*;
#(
   parameter int DEB_CYCLES = 16
) (
   input  logic clk,
   input  logic rstn,
   input  logic raw,
   output logic filt
);

   localparam int CW = $clog2(DEB_CYCLES) + 1;
   localparam logic [CW-1:0] CNT_TC = CW'(DEB_CYCLES - 1);

   logic          sync_1;
   logic          sync_2;
   logic [CW-1:0] stable_cnt;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync_1     <= 1'b0;
         sync_2     <= 1'b0;
         stable_cnt <= '0;
         filt       <= 1'b0;
      end else begin
         sync_1 <= raw;
         sync_2 <= sync_1;
         if (sync_2 == filt) begin
            stable_cnt <= '0;
         end else if (stable_cnt == CNT_TC) begin
            filt       <= sync_2;
            stable_cnt <= '0;
         end else begin
            stable_cnt <= stable_cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/irrigation_ctrl.sv
// Irrigation control stage: filters tank/climate sensors, decodes tank status, sequences the
// sprinkler/drip modes and generates the LED-matrix column-scan clock.
//
// state | meaning
// IDLE  | no irrigation, waiting for dry soil
// DRIP  | drip irrigation (sinal_G), soil dry and not hot
// SPRAY | sprinkler irrigation (sinal_A), soil dry and hot
// FAULT | tank empty or probes inconsistent, nothing irrigates
module irrigation_ctrl
   import irrig_pkg::*;
#(
   parameter int DEB_CYCLES = 16,
   parameter int MIN_RUN    = 1000,
   parameter int SCAN_DIV   = 5000
) (
   input  logic clk,
   input  logic rstn,
   input  logic sensor_l,
   input  logic sensor_m,
   input  logic sensor_h,
   input  logic dry_soil,
   input  logic hot,
   output logic L,
   output logic M,
   output logic H,
   output logic Alarm,
   output logic erro,
   output logic sinal_A,
   output logic sinal_G,
   output logic valve_on,
   output logic delay
);

   localparam int RW = $clog2(MIN_RUN) + 1;
   localparam int SW = $clog2(SCAN_DIV) + 1;
   localparam logic [RW-1:0] RUN_TC  = RW'(MIN_RUN - 1);
   localparam logic [SW-1:0] SCAN_TC = SW'(SCAN_DIV - 1);

   logic          dry_f;
   logic          hot_f;
   logic          probe_bad;
   logic          fault;
   logic          run_done;
   irrig_state_t  state;
   irrig_state_t  state_nxt;
   logic [RW-1:0] run_left;
   logic [SW-1:0] scan_cnt;

   sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_l   (.clk(clk), .rstn(rstn), .raw(sensor_l), .filt(L));
   sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_m   (.clk(clk), .rstn(rstn), .raw(sensor_m), .filt(M));
   sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_h   (.clk(clk), .rstn(rstn), .raw(sensor_h), .filt(H));
   sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dry (.clk(clk), .rstn(rstn), .raw(dry_soil), .filt(dry_f));
   sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_hot (.clk(clk), .rstn(rstn), .raw(hot),      .filt(hot_f));

   assign probe_bad = probe_err(L, M, H);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         erro  <= 1'b0;
         Alarm <= 1'b0;
      end else begin
         erro  <= probe_bad;
         Alarm <= ~L & ~probe_bad;
      end
   end

   assign fault = erro | Alarm;

   // run_left is a down-counter reloaded on every state entry; zero means the minimum run has elapsed.
   assign run_done = (run_left == '0);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (fault)      state_nxt = FAULT;
            else if (dry_f) state_nxt = hot_f ? SPRAY : DRIP;
         end
         DRIP: begin
            if (fault) begin
               state_nxt = FAULT;
            end else if (run_done) begin
               if (!dry_f)     state_nxt = IDLE;
               else if (hot_f) state_nxt = SPRAY;
            end
         end
         SPRAY: begin
            if (fault) begin
               state_nxt = FAULT;
            end else if (run_done) begin
               if (!dry_f)      state_nxt = IDLE;
               else if (!hot_f) state_nxt = DRIP;
            end
         end
         FAULT: begin
            if (!fault) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         run_left <= '0;
         sinal_A  <= 1'b0;
         sinal_G  <= 1'b0;
         valve_on <= 1'b0;
      end else begin
         if (state_nxt != state) begin
            run_left <= RUN_TC;
         end else if (!run_done) begin
            run_left <= run_left - RW'(1);
         end
         sinal_A  <= (state_nxt == SPRAY);
         sinal_G  <= (state_nxt == DRIP);
         valve_on <= (state_nxt == SPRAY) || (state_nxt == DRIP);
      end
   end

   // Free-running scan clock, unaffected by the irrigation state.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         scan_cnt <= '0;
         delay    <= 1'b0;
      end else if (scan_cnt == SCAN_TC) begin
         scan_cnt <= '0;
         delay    <= ~delay;
      end else begin
         scan_cnt <= scan_cnt + SW'(1);
      end
   end

endmodule

// File: tb/tb_irrigation_ctrl.sv
// Bench for irrigation_ctrl: directed scenarios plus a randomized phase, every cycle compared
// against a behavioural model built from the sensor/tank/mode rules.
module tb_irrigation_ctrl;

   localparam int DEB  = 4;
   localparam int MRUN = 8;
   localparam int SDIV = 3;

   logic clk;
   logic rstn;
   logic sensor_l, sensor_m, sensor_h, dry_soil, hot;
   logic L, M, H, Alarm, erro, sinal_A, sinal_G, valve_on, delay;

   int checks = 0;
   int errors = 0;

   irrigation_ctrl #(.DEB_CYCLES(DEB), .MIN_RUN(MRUN), .SCAN_DIV(SDIV)) dut (
      .clk(clk), .rstn(rstn),
      .sensor_l(sensor_l), .sensor_m(sensor_m), .sensor_h(sensor_h),
      .dry_soil(dry_soil), .hot(hot),
      .L(L), .M(M), .H(H), .Alarm(Alarm), .erro(erro),
      .sinal_A(sinal_A), .sinal_G(sinal_G), .valve_on(valve_on), .delay(delay)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef enum int {MD_IDLE, MD_DRIP, MD_SPRAY, MD_FAULT} mode_e;

   // Model: raw samples from the last two edges, filtered values, disagreement run lengths,
   // tank status, mode, cycles spent in the current mode and edges since reset.
   bit    m_prev1 [5];
   bit    m_prev2 [5];
   bit    m_filt  [5];
   int    m_dis   [5];
   bit    m_erro, m_alarm;
   mode_e m_mode;
   int    m_dwell;
   int    m_edges;

   task automatic model_reset();
      for (int i = 0; i < 5; i++) begin
         m_prev1[i] = 1'b0; m_prev2[i] = 1'b0; m_filt[i] = 1'b0; m_dis[i] = 0;
      end
      m_erro = 1'b0; m_alarm = 1'b0; m_mode = MD_IDLE; m_dwell = 0; m_edges = 0;
   endtask

   task automatic model_step();
      bit    raw [5];
      bit    flt, dry, hotv, e_new;
      mode_e nxt;
      raw[0] = sensor_l; raw[1] = sensor_m; raw[2] = sensor_h; raw[3] = dry_soil; raw[4] = hot;
      flt  = m_erro | m_alarm;
      dry  = m_filt[3];
      hotv = m_filt[4];
      nxt  = m_mode;
      case (m_mode)
         MD_IDLE:  if (flt) nxt = MD_FAULT; else if (dry) nxt = hotv ? MD_SPRAY : MD_DRIP;
         MD_FAULT: if (!flt) nxt = MD_IDLE;
         default: begin
            if (flt) nxt = MD_FAULT;
            else if (m_dwell >= MRUN - 1) begin
               if (!dry) nxt = MD_IDLE;
               else if (m_mode == MD_DRIP && hotv) nxt = MD_SPRAY;
               else if (m_mode == MD_SPRAY && !hotv) nxt = MD_DRIP;
            end
         end
      endcase
      m_dwell = (nxt != m_mode) ? 0 : m_dwell + 1;
      m_mode  = nxt;
      e_new   = (m_filt[1] && !m_filt[0]) || (m_filt[2] && !m_filt[1]);
      m_alarm = !m_filt[0] && !e_new;
      m_erro  = e_new;
      for (int i = 0; i < 5; i++) begin
         if (m_prev2[i] != m_filt[i]) begin
            m_dis[i]++;
            if (m_dis[i] == DEB) begin
               m_filt[i] = m_prev2[i];
               m_dis[i]  = 0;
            end
         end else begin
            m_dis[i] = 0;
         end
         m_prev2[i] = m_prev1[i];
         m_prev1[i] = raw[i];
      end
      m_edges++;
   endtask

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".L"},        L,        m_filt[0]);
      chk({tag, ".M"},        M,        m_filt[1]);
      chk({tag, ".H"},        H,        m_filt[2]);
      chk({tag, ".Alarm"},    Alarm,    m_alarm);
      chk({tag, ".erro"},     erro,     m_erro);
      chk({tag, ".sinal_A"},  sinal_A,  m_mode == MD_SPRAY);
      chk({tag, ".sinal_G"},  sinal_G,  m_mode == MD_DRIP);
      chk({tag, ".valve_on"}, valve_on, m_mode == MD_SPRAY || m_mode == MD_DRIP);
      chk({tag, ".delay"},    delay,    ((m_edges / SDIV) % 2) == 1);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, ".L"}, L, 1'b0);             chk({tag, ".M"}, M, 1'b0);
      chk({tag, ".H"}, H, 1'b0);             chk({tag, ".Alarm"}, Alarm, 1'b0);
      chk({tag, ".erro"}, erro, 1'b0);       chk({tag, ".sinal_A"}, sinal_A, 1'b0);
      chk({tag, ".sinal_G"}, sinal_G, 1'b0); chk({tag, ".valve_on"}, valve_on, 1'b0);
      chk({tag, ".delay"}, delay, 1'b0);
   endtask

   task automatic ticks(input int n, input string tag);
      repeat (n) begin
         @(posedge clk);
         model_step();
         @(negedge clk);
         check_model(tag);
      end
   endtask

   initial begin
      sensor_l = 1'b0; sensor_m = 1'b0; sensor_h = 1'b0; dry_soil = 1'b0; hot = 1'b0;
      rstn = 1'b1;
      model_reset();
      #1 rstn = 1'b0;
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      rstn = 1'b1;

      // Empty tank from reset lands in FAULT with the alarm raised; scan clock runs.
      ticks(DEB + 3, "empty");
      chk("empty.alarm", Alarm, 1'b1);
      chk("empty.valve", valve_on, 1'b0);

      // Short glitch is rejected, a sustained level is accepted after 2+DEB cycles.
      sensor_l = 1'b1;
      ticks(3, "glitch");
      sensor_l = 1'b0;
      ticks(10, "glitch");
      chk("glitch.L", L, 1'b0);
      sensor_l = 1'b1;
      ticks(5, "level");
      chk("level.L_early", L, 1'b0);
      ticks(1, "level");
      chk("level.L", L, 1'b1);
      ticks(3, "level");
      chk("level.alarm_clear", Alarm, 1'b0);

      // Drip, then hot arrives at run cycle 2: spray only once the minimum run has elapsed.
      dry_soil = 1'b1; hot = 1'b0;
      ticks(7, "drip");
      chk("drip.G", sinal_G, 1'b1);
      chk("drip.valve", valve_on, 1'b1);
      ticks(2, "drip");
      hot = 1'b1;
      ticks(6, "drip_hot");
      chk("drip_hot.G_held", sinal_G, 1'b1);
      chk("drip_hot.A_held", sinal_A, 1'b0);
      ticks(1, "spray");
      chk("spray.A", sinal_A, 1'b1);

      // Inconsistent probes during spray force FAULT; clearing them re-enters spray via IDLE.
      sensor_m = 1'b1; sensor_l = 1'b0;
      ticks(8, "probe_err");
      chk("probe_err.erro", erro, 1'b1);
      chk("probe_err.A", sinal_A, 1'b0);
      sensor_m = 1'b0; sensor_l = 1'b1;
      ticks(10, "recover");
      chk("recover.A", sinal_A, 1'b1);

      // Dry drops at drip run cycle 1: drip holds until the minimum run, then IDLE.
      dry_soil = 1'b0; hot = 1'b0;
      ticks(20, "to_idle");
      chk("to_idle.valve", valve_on, 1'b0);
      dry_soil = 1'b1;
      ticks(7, "drip2");
      chk("drip2.G", sinal_G, 1'b1);
      ticks(1, "drip2");
      dry_soil = 1'b0;
      ticks(6, "drip2_hold");
      chk("drip2_hold.G", sinal_G, 1'b1);
      ticks(1, "drip2_end");
      chk("drip2_end.valve", valve_on, 1'b0);

      // Asynchronous reset mid-spray clears everything before the next clock edge.
      dry_soil = 1'b1; hot = 1'b1;
      ticks(12, "spray2");
      chk("spray2.A", sinal_A, 1'b1);
      #3 rstn = 1'b0;
      model_reset();
      #1 check_all_zero("async_rst");
      @(negedge clk);
      rstn = 1'b1;

      // Randomized sensor activity with mostly-plausible tank levels.
      for (int seg = 0; seg < 160; seg++) begin
         int lvl;
         lvl = $urandom_range(0, 9);
         case (lvl)
            0, 1:    {sensor_h, sensor_m, sensor_l} = 3'b001;
            2, 3:    {sensor_h, sensor_m, sensor_l} = 3'b011;
            4, 5:    {sensor_h, sensor_m, sensor_l} = 3'b111;
            6:       {sensor_h, sensor_m, sensor_l} = 3'b000;
            default: {sensor_h, sensor_m, sensor_l} = 3'($urandom_range(0, 7));
         endcase
         if ($urandom_range(0, 2) != 0) dry_soil = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 2) != 0) hot      = 1'($urandom_range(0, 1));
         ticks($urandom_range(1, 16), "random");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
